fadd64_sched: RTL and testbench

- Shares one pipelined 64-bit FP adder datapath (fadd64) among NREQ requesters.
- Round-robin arbitration over add/sub requests; drives datapath operands.
- Tracks in-flight ops with an ID tag pipeline matched to datapath latency.
- Returns results in issue order through a credit-protected result FIFO, since the datapath cannot stall.

---
 rtl/fadd_pkg.sv | 23 ++
 rtl/fadd64_sched_rr_arb.sv | 43 ++++
 rtl/fadd64_sched.sv | 161 ++++++++++++++++
 tb/tb_fadd64_sched.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fadd_pkg.sv
// fadd_pkg: shared types and constants for the fadd64 scheduler slice.
package fadd_pkg;

    localparam int FP_SIGN_BIT = 63;
    localparam int NREQ_MAX    = 8;
    localparam int SCHED_ID_W  = $clog2(NREQ_MAX);

    typedef logic [63:0] fp64_t;

    typedef struct packed {
        logic                  valid;
        logic [SCHED_ID_W-1:0] id;
    } sched_tag_t;

    // Flip the sign of an FP64 value when neg is set (turns A+B into A-B).
    function automatic fp64_t fp_negate_if(input fp64_t x, input logic neg);
        fp64_t r;
        r = x;
        r[FP_SIGN_BIT] = x[FP_SIGN_BIT] ^ neg;
        return r;
    endfunction

endpackage

// File: rtl/fadd64_sched_rr_arb.sv
// rr_arb: NREQ-wide round-robin arbiter with registered pointer and grant enable.
module rr_arb #(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] ptr;
    logic          found;

    // Pick the first requester at or above the pointer, wrapping around.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        grant     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NREQ]) begin
                found     = 1'b1;
                grant_idx = IW'((int'(ptr) + k) % NREQ);
            end
        end
        if (en && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Advance the pointer past the winner on every transfer; hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en && found) begin
            ptr <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/fadd64_sched.sv
// fadd64_sched: round-robin scheduler sharing one non-stallable pipelined fadd64
// datapath among NREQ requesters, with in-order result return through a
// credit-protected FIFO.
// Optional macro FADD_SCHED_BYPASS_EN: results skip the FIFO when it is empty
// and the consumer is ready.
module fadd64_sched
    import fadd_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    parameter int RBUF = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_vld,
    input  logic [NREQ*64-1:0]      req_a,
    input  logic [NREQ*64-1:0]      req_b,
    input  logic [NREQ-1:0]         req_sub,
    output logic [NREQ-1:0]         req_rdy,
    output logic                    dp_vld,
    output logic [63:0]             dp_a,
    output logic [63:0]             dp_b,
    input  logic [63:0]             dp_res,
    output logic                    res_vld,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic [63:0]             res_data,
    input  logic                    res_rdy
);

    localparam int IDW = $clog2(NREQ);
    localparam int PW  = $clog2(RBUF);
    localparam int CW  = PW + 1;

    typedef struct packed {
        logic [IDW-1:0] id;
        fp64_t          data;
    } fifo_ent_t;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            issue_ok;
    logic            xfer;
    int              inflight;

    // Stage 0 is the issue register; stage LAT lines up with dp_res.
    sched_tag_t      tag_p [0:LAT];

    fifo_ent_t       fifo_mem [RBUF];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    logic            empty;
    logic            full;
    logic            bypass;

    // Every op from the issue register onward owns one result slot; popping
    // returns its slot only once the count register has dropped.
    always_comb begin
        inflight = int'(count);
        for (int s = 0; s <= LAT; s++) begin
            inflight += int'(tag_p[s].valid);
        end
    end

    assign issue_ok = !rst && (inflight < RBUF);

    rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (issue_ok),
        .req       (req_vld),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_rdy = grant;
    assign xfer    = |grant;
    assign dp_vld  = tag_p[0].valid;

    // ---- arbitration -> issue register (p0) -> tag stages p1..pLAT ----
    // Issue register drives the datapath; tags shadow the datapath latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= LAT; s++) begin
                tag_p[s] <= '0;
            end
            dp_a <= '0;
            dp_b <= '0;
        end else begin
            tag_p[0].valid <= xfer;
            tag_p[0].id    <= SCHED_ID_W'(grant_idx);
            if (xfer) begin
                dp_a <= req_a[64*grant_idx +: 64];
                dp_b <= fp_negate_if(req_b[64*grant_idx +: 64], req_sub[grant_idx]);
            end
            for (int s = 1; s <= LAT; s++) begin
                tag_p[s] <= tag_p[s-1];
            end
        end
    end

    assign empty = (count == '0);
    assign full  = (count == CW'(RBUF));

`ifdef FADD_SCHED_BYPASS_EN
    assign bypass = empty && tag_p[LAT].valid && res_rdy;
`else
    assign bypass = 1'b0;
`endif

    assign push = tag_p[LAT].valid && !bypass;
    assign pop  = !empty && res_rdy;

    // ---- tag stage pLAT -> result FIFO ----
    // Result FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wptr].id   <= IDW'(tag_p[LAT].id);
                fifo_mem[wptr].data <= dp_res;
                wptr                <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Present the FIFO head, or the arriving result when it bypasses the FIFO.
    always_comb begin
        res_vld  = !empty;
        res_id   = empty ? '0 : fifo_mem[rptr].id;
        res_data = empty ? '0 : fifo_mem[rptr].data;
        if (bypass) begin
            res_vld  = 1'b1;
            res_id   = IDW'(tag_p[LAT].id);
            res_data = dp_res;
        end
    end

    // Credits must keep a push from ever landing on a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full));
        end
    end

endmodule

// File: tb/tb_fadd64_sched.sv
// tb_fadd64_sched: scoreboard bench for fadd64_sched with an FP64 datapath model.
module tb_fadd64_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int RBUF = 4;
    localparam int IDW  = 2;
`ifdef FADD_SCHED_BYPASS_EN
    localparam int LAT_EXP = LAT + 1;
`else
    localparam int LAT_EXP = LAT + 2;
`endif

    // Per-requester operands: 1-1, 2+1, 1+1, 1.5-0.5
    localparam logic [63:0] OP_A [4] = '{64'h3FF0000000000000, 64'h4000000000000000,
                                         64'h3FF0000000000000, 64'h3FF8000000000000};
    localparam logic [63:0] OP_B [4] = '{64'h3FF0000000000000, 64'h3FF0000000000000,
                                         64'h3FF0000000000000, 64'h3FE0000000000000};
    localparam logic [3:0]  OP_SUB   = 4'b1001;
    localparam logic [63:0] DPB_EXP [4] = '{64'hBFF0000000000000, 64'h3FF0000000000000,
                                            64'h3FF0000000000000, 64'hBFE0000000000000};
    localparam logic [63:0] RES_EXP [4] = '{64'h0000000000000000, 64'h4008000000000000,
                                            64'h4000000000000000, 64'h3FF0000000000000};

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_vld;
    logic [NREQ*64-1:0]  req_a;
    logic [NREQ*64-1:0]  req_b;
    logic [NREQ-1:0]     req_sub;
    logic [NREQ-1:0]     req_rdy;
    logic                dp_vld;
    logic [63:0]         dp_a;
    logic [63:0]         dp_b;
    logic [63:0]         dp_res;
    logic                res_vld;
    logic [IDW-1:0]      res_id;
    logic [63:0]         res_data;
    logic                res_rdy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rr_ptr = 0;

    typedef struct {
        logic [IDW-1:0] id;
        logic [63:0]    data;
        int             t0;
        bit             chk_lat;
    } exp_t;
    exp_t sbq[$];

    fadd64_sched #(.NREQ(NREQ), .LAT(LAT), .RBUF(RBUF)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_sub  (req_sub),
        .req_rdy  (req_rdy),
        .dp_vld   (dp_vld),
        .dp_a     (dp_a),
        .dp_b     (dp_b),
        .dp_res   (dp_res),
        .res_vld  (res_vld),
        .res_id   (res_id),
        .res_data (res_data),
        .res_rdy  (res_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Two-stage FP64 adder model: dp_res is valid LAT cycles after dp_vld.
    logic [63:0] m1, m2;
    always @(posedge clk) begin
        m1 <= $realtobits($bitstoreal(dp_a) + $bitstoreal(dp_b));
        m2 <= m1;
    end
    assign dp_res = m2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int i, input bit lat);
        exp_t e;
        e.id      = IDW'(i);
        e.data    = RES_EXP[i];
        e.t0      = cyc;
        e.chk_lat = lat;
        sbq.push_back(e);
    endtask

    // Monitor: pop and compare on every accepted result; check head while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && res_vld) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got id %0d data %h want none", res_id, res_data);
            end else if (res_rdy) begin
                e = sbq.pop_front();
                chk("res_id", 64'(res_id), 64'(e.id));
                chk("res_data", res_data, e.data);
                if (e.chk_lat) chk("latency", 64'(cyc - e.t0), 64'(LAT_EXP));
            end else begin
                chk("res_hold", res_data, sbq[0].data);
            end
        end
    end

    task automatic drain(input int n);
        for (int k = 0; k < n && sbq.size() != 0; k++) @(negedge clk);
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending %0d results, want 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic single(input int i);
        @(posedge clk); #1;
        req_vld = 4'(1 << i);
        @(negedge clk);
        chk("grant_single", 64'(req_rdy), 64'(1 << i));
        push_exp(i, 1'b1);
        rr_ptr = (i + 1) % NREQ;
        @(posedge clk); #1;
        req_vld = '0;
        @(negedge clk);
        chk("dp_vld", 64'(dp_vld), 64'd1);
        chk("dp_a", dp_a, OP_A[i]);
        chk("dp_b", dp_b, DPB_EXP[i]);
        drain(20);
    endtask

    // Caller sits just after a posedge with req_vld all ones.
    task automatic stream(input int ngrants, input int maxcyc, output int got);
        got = 0;
        for (int k = 0; k < maxcyc && got < ngrants; k++) begin
            @(negedge clk);
            if (req_rdy != '0) begin
                chk("rr_grant", 64'(req_rdy), 64'(1 << rr_ptr));
                push_exp(rr_ptr, 1'b0);
                rr_ptr = (rr_ptr + 1) % NREQ;
                got++;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int got;
        rst     = 1'b1;
        req_vld = '1;
        req_sub = OP_SUB;
        res_rdy = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[64*i +: 64] = OP_A[i];
            req_b[64*i +: 64] = OP_B[i];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);
        chk("rst_dp_vld", 64'(dp_vld), 64'd0);
        chk("rst_res_vld", 64'(res_vld), 64'd0);
        chk("rst_res_id", 64'(res_id), 64'd0);
        chk("rst_res_data", res_data, 64'd0);
        chk("rst_dp_a", dp_a, 64'd0);
        chk("rst_dp_b", dp_b, 64'd0);
        @(posedge clk); #1;
        rst     = 1'b0;
        req_vld = '0;

        // single ops, ending with the pointer back at 0
        single(2);
        single(0);
        single(1);
        single(3);

        // round robin with all requesting
        @(posedge clk); #1;
        req_vld = '1;
        stream(5, 20, got);
        req_vld = '0;
        chk("rr_count", 64'(got), 64'd5);
        drain(30);

        // back-pressure: exactly RBUF grants, then stall
        @(posedge clk); #1;
        res_rdy = 1'b0;
        req_vld = '1;
        stream(99, 12, got);
        chk("bp_count", 64'(got), 64'(RBUF));
        chk("bp_res_vld", 64'(res_vld), 64'd1);
        res_rdy = 1'b1;
        @(negedge clk);
        chk("bp_no_grant_pop_cycle", 64'(req_rdy), 64'd0);
        @(posedge clk); #1;
        stream(7, 30, got);
        req_vld = '0;
        chk("bp_resume_count", 64'(got), 64'd7);
        drain(40);

        // reset with two ops in flight
        @(posedge clk); #1;
        req_vld = 4'b0011;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_vld = '0;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        rr_ptr = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("midrst_res_vld", 64'(res_vld), 64'd0);
            chk("midrst_dp_vld", 64'(dp_vld), 64'd0);
        end
        single(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule
